// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the 4x4 keypad scanner and its debouncer.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ENTRY_W  = 14;

  localparam logic [CODE_W-1:0] KEY_BKSP = 4'hB;
  localparam logic [CODE_W-1:0] KEY_CLR  = 4'hC;
  localparam logic [CODE_W-1:0] KEY_MAX_DIGIT = 4'h9;

  typedef enum logic {IDLE, HELD} fsm_state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_result_e;

  // Pmod KYPD layout: rows top-to-bottom, columns left-to-right.
  function automatic logic [CODE_W-1:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [CODE_W-1:0] code;
    code = '0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = '0;
    endcase
    return code;
  endfunction

  // Decimal entry update: shift in a digit (dropping the oldest), clear, or backspace.
  function automatic logic [ENTRY_W-1:0] next_entry(input logic [ENTRY_W-1:0] entry,
                                                    input logic [CODE_W-1:0]  code);
    logic [ENTRY_W-1:0] result;
    result = entry;
    if (code <= KEY_MAX_DIGIT) begin
      result = (entry % ENTRY_W'(1000)) * ENTRY_W'(10) + ENTRY_W'(code);
    end else if (code == KEY_CLR) begin
      result = '0;
    end else if (code == KEY_BKSP) begin
      result = entry / ENTRY_W'(10);
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Accepts a key after DEBOUNCE_SCANS identical single-key scans; re-arms after as many empty scans.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_done,
  input  scan_result_e      scan_result,
  input  logic [CODE_W-1:0] scan_code,
  output logic              event_c,
  output logic [CODE_W-1:0] event_code_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  fsm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  scan_result_e      prev_result_q;
  logic [CODE_W-1:0] prev_code_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prev_result_q <= NONE;
      prev_code_q   <= '0;
    end else if (scan_done) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_result_q <= scan_result;
      prev_code_q   <= scan_code;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    event_c      = 1'b0;
    event_code_c = scan_code;
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (scan_result == SINGLE && prev_result_q == SINGLE && scan_code == prev_code_q) begin
            cnt_d = cnt_inc;
          end else if (scan_result == SINGLE) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
          if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
            event_c = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        HELD: begin
          cnt_d = (scan_result == NONE) ? cnt_inc : '0;
          if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// Column-scanning 4x4 keypad decoder with debounce, valid/ready key events and a 4-digit entry.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned DATA_LEN       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_overrun,
  output logic [DATA_LEN-1:0] entry_value
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [NUM_ROWS-1:0] row_s1, row_s2, row_low;
  logic [DIV_W-1:0]    div_q;
  logic [1:0]          col_idx_q, col_next;
  logic                col_tick;
  logic [1:0]          acc_cnt_q, new_cnt;
  logic [CODE_W-1:0]   acc_code_q, new_code;
  logic [2:0]          col_hits, hit_sum;
  logic [1:0]          hit_row, base_cnt;
  scan_result_e        new_result, scan_result_q;
  logic                scan_done_q;
  logic [CODE_W-1:0]   scan_code_q;
  logic                key_event_c;
  logic [CODE_W-1:0]   event_code_c;
  logic [ENTRY_W-1:0]  entry_q;

  assign col_tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign col_next    = col_idx_q + 2'd1;
  assign row_low     = ~row_s2;
  assign entry_value = DATA_LEN'(entry_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Merge this column's low rows into the running scan tally; saturate at 2 (ghosting).
  always_comb begin
    col_hits = 3'd0;
    hit_row  = 2'd0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (row_low[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    base_cnt   = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
    hit_sum    = {1'b0, base_cnt} + col_hits;
    new_cnt    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    new_code   = (col_hits == 3'd1) ? key_map(hit_row, col_idx_q) : acc_code_q;
    new_result = MULTI;
    if (new_cnt == 2'd0) begin
      new_result = NONE;
    end else if (new_cnt == 2'd1) begin
      new_result = SINGLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      col_idx_q     <= 2'd0;
      col_out       <= 4'b1110;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= '0;
      scan_done_q   <= 1'b0;
      scan_result_q <= NONE;
      scan_code_q   <= '0;
    end else begin
      scan_done_q <= 1'b0;
      if (col_tick) begin
        div_q      <= '0;
        col_idx_q  <= col_next;
        col_out    <= ~(4'b0001 << col_next);
        acc_cnt_q  <= new_cnt;
        acc_code_q <= new_code;
        if (col_idx_q == 2'd3) begin
          scan_done_q   <= 1'b1;
          scan_result_q <= new_result;
          scan_code_q   <= new_code;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .scan_done   (scan_done_q),
    .scan_result (scan_result_q),
    .scan_code   (scan_code_q),
    .event_c     (key_event_c),
    .event_code_c(event_code_c)
  );

  // Every event updates the entry, even when the handshake has to drop it.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
      entry_q     <= '0;
    end else begin
      key_overrun <= 1'b0;
      if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (key_event_c) begin
        if (!key_valid || key_ready) begin
          key_code  <= event_code_c;
          key_valid <= 1'b1;
        end else begin
          key_overrun <= 1'b1;
        end
        entry_q <= next_entry(entry_q, event_code_c);
      end
    end
  end

endmodule
